// File: rtl/ms_timer_mc_pkg.sv
// ms_timer_mc_pkg
// ---------------
// Shared definitions for the multi-channel millisecond timer.
// Holds the bus register map (word addresses within the block), the bit
// offset of the periodic-mode field inside the control register, and a
// helper that maps a channel index to its register address.
package ms_timer_mc_pkg;

  // Word addresses on the 4-bit block-local bus
  localparam logic [3:0] ADDR_TICKS = 4'd0;  // free-running tick counter
  localparam logic [3:0] ADDR_FLAGS = 4'd1;  // sticky expiry flags, W1C
  localparam logic [3:0] ADDR_CTRL  = 4'd2;  // enable / periodic mode
  localparam logic [3:0] ADDR_MASK  = 4'd3;  // interrupt mask
  localparam logic [3:0] ADDR_CH0   = 4'd4;  // first channel register

  // Control register: enables sit at bit 0 upwards, modes at this offset
  localparam int MODE_OFS = 16;

  // Register address of channel idx
  function automatic logic [3:0] ch_addr(input int idx);
    return ADDR_CH0 + 4'(idx);
  endfunction

endpackage

// File: rtl/ms_timer_mc_ch.sv
// ms_timer_ch
// -----------
// One down-counting timer channel.
// On a tick with the channel enabled and a non-zero count, the count steps
// down; reaching the end of a period (count==1 on a tick) raises expire for
// that cycle and either reloads the period (periodic) or parks at 0 and asks
// the owner to clear the enable bit (one-shot). A load overrides everything
// in its cycle: period and count both take load_val and no step happens.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   tick      in   shared prescaler tick pulse
//   enable    in   channel enable (current register value)
//   periodic  in   1 = reload on expiry, 0 = one-shot
//   load      in   bus write to this channel's register
//   load_val  in   new period / count
//   count     out  current count, for readback
//   expire    out  combinational: this cycle ends a period
//   en_clr    out  combinational: one-shot expiry, enable must drop
module ms_timer_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic             periodic,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expire,
  output logic             en_clr
);

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             step;

  always_comb begin
    // A zero count never moves: a period of 0 means "never expires"
    step     = tick & enable & (count_q != '0);
    // A same-cycle load wins, so it also suppresses the expiry
    expire   = step & (count_q == CNT_W'(1)) & ~load;
    en_clr   = expire & ~periodic;

    period_d = period_q;
    count_d  = count_q;
    if (load) begin
      period_d = load_val;
      count_d  = load_val;
    end else if (step) begin
      if (count_q == CNT_W'(1)) begin
        count_d = periodic ? period_q : '0;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q <= '0;
      count_q  <= '0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ms_timer_mc.sv
// ms_timer_mc
// -----------
// Multi-channel millisecond timer on the single-cycle base-device bus.
// A shared prescaler divides clk down to a tick pulse; a 32-bit counter
// counts ticks; NUM_CH channels count ticks down and set sticky flags on
// expiry. irq is the OR of flags under irq_mask.
//
// Register map (word address):
//   0      tick counter, RW (write beats a same-cycle tick)
//   1      flags, read / write-1-to-clear (hardware set beats clear)
//   2      control: [NUM_CH-1:0] enable, [16 +: NUM_CH] periodic mode
//   3      irq_mask
//   4+i    channel i: write loads period and count, read returns count
//   other  read 0, writes ignored
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   stb       in   bus strobe
//   we        in   write enable, qualified by stb
//   addr      in   word address
//   data_in   in   write data
//   data_out  out  read data, 0 unless stb & ~we
//   ack       out  = stb, zero wait states
//   tick      out  one-cycle pulse per tick period
//   irq       out  |(flags & irq_mask)
module ms_timer_mc
  import ms_timer_mc_pkg::*;
#(
  parameter int CLOCK_FREQ = 40_000_000,
  parameter int TICK_FREQ  = 1000,
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        tick,
  output logic        irq
);

  localparam int DIV   = CLOCK_FREQ / TICK_FREQ;
  localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

  // Elaboration-time parameter checks
  if (DIV < 2 || (CLOCK_FREQ % TICK_FREQ) != 0) begin : g_bad_div
    $error("ms_timer_mc: CLOCK_FREQ/TICK_FREQ must be an integer >= 2");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("ms_timer_mc: NUM_CH must be 1..8");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_w
    $error("ms_timer_mc: CNT_W must be 1..32");
  end

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [31:0]       ticks_q, ticks_d;
  logic [NUM_CH-1:0] flags_q, flags_d;
  logic [NUM_CH-1:0] enable_q, enable_d;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] mask_q, mask_d;

  logic              wr;
  logic              rd;
  logic [NUM_CH-1:0] ch_load;
  logic [NUM_CH-1:0] ch_expire;
  logic [NUM_CH-1:0] ch_en_clr;
  logic [CNT_W-1:0]  ch_count [NUM_CH];

  // Many data_in bits are architecturally don't-care
  logic unused_data_in;
  assign unused_data_in = ^data_in;

  assign wr   = stb & we;
  assign rd   = stb & ~we;
  assign ack  = stb;
  assign tick = (pre_q == PRE_W'(DIV - 1));
  assign irq  = |(flags_q & mask_q);

  // ------------------------------------------------------------------
  // Channels
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_load[gi] = wr & (addr == ch_addr(gi));

    ms_timer_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .enable   (enable_q[gi]),
      .periodic (mode_q[gi]),
      .load     (ch_load[gi]),
      .load_val (data_in[CNT_W-1:0]),
      .count    (ch_count[gi]),
      .expire   (ch_expire[gi]),
      .en_clr   (ch_en_clr[gi])
    );
  end

  // ------------------------------------------------------------------
  // Next-state logic for the shared registers
  // ------------------------------------------------------------------
  always_comb begin
    pre_d = tick ? '0 : pre_q + PRE_W'(1);

    ticks_d = ticks_q;
    if (wr && addr == ADDR_TICKS) begin
      ticks_d = data_in;
    end else if (tick) begin
      ticks_d = ticks_q + 32'd1;
    end

    // Clear first, then OR in fresh expiries so hardware set wins
    flags_d = flags_q;
    if (wr && addr == ADDR_FLAGS) begin
      flags_d = flags_q & ~data_in[NUM_CH-1:0];
    end
    flags_d = flags_d | ch_expire;

    // Channels see enable_q/mode_q this cycle, so a control write only
    // takes effect from the next tick; one-shot auto-clear beats the write
    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr && addr == ADDR_CTRL) begin
      enable_d = data_in[NUM_CH-1:0];
      mode_d   = data_in[MODE_OFS +: NUM_CH];
    end
    enable_d = enable_d & ~ch_en_clr;

    mask_d = mask_q;
    if (wr && addr == ADDR_MASK) begin
      mask_d = data_in[NUM_CH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q    <= '0;
      ticks_q  <= '0;
      flags_q  <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      mask_q   <= '0;
    end else begin
      pre_q    <= pre_d;
      ticks_q  <= ticks_d;
      flags_q  <= flags_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      mask_q   <= mask_d;
    end
  end

  // ------------------------------------------------------------------
  // Read mux (combinational, zero wait states)
  // ------------------------------------------------------------------
  always_comb begin
    data_out = '0;
    if (rd) begin
      case (addr)
        ADDR_TICKS: data_out = ticks_q;
        ADDR_FLAGS: data_out[NUM_CH-1:0] = flags_q;
        ADDR_CTRL: begin
          data_out[NUM_CH-1:0]         = enable_q;
          data_out[MODE_OFS +: NUM_CH] = mode_q;
        end
        ADDR_MASK:  data_out[NUM_CH-1:0] = mask_q;
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (addr == ch_addr(i)) begin
              data_out = 32'(ch_count[i]);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ms_timer_mc.sv
// Self-checking bench for ms_timer_mc (DIV = 10, 4 channels, 16-bit).
// A behavioural model steps once per clock; a compare process checks
// tick, irq, ack and data_out against it on every falling edge. Directed
// sections pin the model with hand-derived literals, then a random phase
// exercises the register map.
module tb_ms_timer_mc;

  localparam int CF  = 10_000;
  localparam int TF  = 1000;
  localparam int DIV = CF / TF;
  localparam int NCH = 4;
  localparam int CW  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        ack;
  logic        tick;
  logic        irq;

  always #5 clk = ~clk;

  ms_timer_mc #(
    .CLOCK_FREQ (CF),
    .TICK_FREQ  (TF),
    .NUM_CH     (NCH),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .tick     (tick),
    .irq      (irq)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned    m_cyc;          // cycles since reset release, mod DIV
  logic [31:0]    m_ticks;
  logic [CW-1:0]  m_cnt [NCH];
  logic [CW-1:0]  m_per [NCH];
  logic [NCH-1:0] m_flags, m_en, m_mode, m_mask;
  logic [NCH-1:0] m_fire, m_clr;
  logic           m_t, m_wr;

  function automatic logic m_tick();
    return rst && (m_cyc == DIV - 1);
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      4'd0: r = m_ticks;
      4'd1: r = 32'(m_flags);
      4'd2: r = 32'(m_en) | (32'(m_mode) << 16);
      4'd3: r = 32'(m_mask);
      4'd4, 4'd5, 4'd6, 4'd7: r = 32'(m_cnt[int'(a) - 4]);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cyc = 0; m_ticks = 0; m_flags = 0; m_en = 0; m_mode = 0; m_mask = 0;
      for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_per[i] = 0; end
    end else begin
      m_t = (m_cyc == DIV - 1);
      m_wr = stb && we;
      m_fire = 0;
      m_clr = 0;
      if (m_wr && addr == 4'd0) m_ticks = data_in;
      else if (m_t) m_ticks = m_ticks + 1;
      for (int i = 0; i < NCH; i++) begin
        if (m_wr && int'(addr) == 4 + i) begin
          m_per[i] = data_in[CW-1:0];
          m_cnt[i] = data_in[CW-1:0];
        end else if (m_t && m_en[i] && m_cnt[i] != 0) begin
          if (m_cnt[i] == 1) begin
            m_fire[i] = 1'b1;
            if (m_mode[i]) m_cnt[i] = m_per[i];
            else begin m_cnt[i] = 0; m_clr[i] = 1'b1; end
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
      if (m_wr && addr == 4'd1) m_flags = m_flags & ~data_in[NCH-1:0];
      m_flags = m_flags | m_fire;
      if (m_wr && addr == 4'd2) begin
        m_en   = data_in[NCH-1:0];
        m_mode = data_in[16 +: NCH];
      end
      m_en = m_en & ~m_clr;
      if (m_wr && addr == 4'd3) m_mask = data_in[NCH-1:0];
      m_cyc = (m_cyc + 1) % DIV;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("tick", 32'(tick), 32'(m_tick()));
    check("irq", 32'(irq), 32'(|(m_flags & m_mask)));
    check("ack", 32'(ack), 32'(stb));
    check("data_out", data_out, (stb && !we) ? m_read(addr) : 32'd0);
  end

  // ---------------- stimulus helpers (enter/leave at posedge+2) ----------------
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    next();
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    stb = 1'b1; we = 1'b0; addr = a;
    #1;
    d = data_out;
    @(posedge clk);
    #2;
    stb = 1'b0;
  endtask

  // Leaves the caller at posedge+3 inside a tick cycle
  task automatic wait_tick();
    int g;
    g = 0;
    #1;
    while (!tick && g < 30) begin
      @(posedge clk); #3; g++;
    end
    check("wait_tick", 32'(tick), 32'd1);
  endtask

  // Leaves the caller at posedge+3 inside the cycle where ch0 expires
  task automatic wait_exp();
    int g;
    g = 0;
    stb = 1'b1; we = 1'b0; addr = 4'd4;
    #1;
    while (!(tick && data_out == 32'd1) && g < 100) begin
      @(posedge clk); #3; g++;
    end
    check("wait_expire", 32'(tick && data_out == 32'd1), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] prev;
    logic [31:0] seq [6];
    logic [31:0] exp_seq [6];
    int k, g, nt, r;

    exp_seq[0] = 2; exp_seq[1] = 1; exp_seq[2] = 3;
    exp_seq[3] = 2; exp_seq[4] = 1; exp_seq[5] = 3;

    // 1. reset release, tick cadence
    repeat (3) @(posedge clk);
    #2;
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    rst = 1'b1;
    nt = 0;
    for (int c = 0; c < 35; c++) begin
      #1;
      check("t1_tick_cycle", 32'(tick), 32'(c == 9 || c == 19 || c == 29));
      nt += int'(tick);
      @(posedge clk);
      #2;
    end
    check("t1_tick_pulses", 32'(nt), 32'd3);
    check("t1_irq", 32'(irq), 32'd0);
    bus_rd(4'd0, v);
    check("t1_ticks", v, 32'd3);

    // 2. ch0 periodic, period 3
    bus_wr(4'd2, 32'h0001_0001);
    bus_wr(4'd3, 32'h1);
    bus_wr(4'd4, 32'd3);
    stb = 1'b1; we = 1'b0; addr = 4'd4;
    #1;
    prev = data_out;
    check("t2_load", prev, 32'd3);
    k = 0; g = 0;
    while (k < 6 && g < 200) begin
      @(posedge clk); #1; g++;
      v = data_out;
      if (v != prev) begin
        seq[k] = v;
        if (k == 2) check("t2_irq_rise", 32'(irq), 32'd1);
        k++;
        prev = v;
      end
    end
    #1;
    stb = 1'b0;
    check("t2_transitions", 32'(k), 32'd6);
    for (int i = 0; i < 6; i++) check("t2_ch0_seq", seq[i], exp_seq[i]);
    bus_wr(4'd1, 32'h1);
    #1;
    check("t2_irq_clear", 32'(irq), 32'd0);
    #1;

    // 3. ch1 one-shot, period 2
    bus_wr(4'd5, 32'd2);
    bus_wr(4'd2, 32'h0001_0003);
    repeat (40) next();
    bus_rd(4'd1, v);
    check("t3_flag1", 32'(v[1]), 32'd1);
    bus_rd(4'd5, v);
    check("t3_ch1_count", v, 32'd0);
    bus_rd(4'd2, v);
    check("t3_en1_cleared", 32'(v[1]), 32'd0);
    check("t3_en0_kept", 32'(v[0]), 32'd1);
    bus_wr(4'd1, 32'h2);
    repeat (100) next();
    bus_rd(4'd1, v);
    check("t3_no_refire", 32'(v[1]), 32'd0);

    // 4. tick counter wrap
    bus_wr(4'd0, 32'hFFFF_FFFF);
    wait_tick();
    #1;
    next();
    bus_rd(4'd0, v);
    check("t4_wrap", v, 32'd0);

    // 5. simultaneous events
    wait_exp();
    #1;
    stb = 1'b0;
    next();
    bus_wr(4'd1, 32'h1);
    bus_rd(4'd1, v);
    check("t5_flag_cleared", 32'(v[0]), 32'd0);
    wait_exp();
    we = 1'b1; addr = 4'd1; data_in = 32'h1;
    #1;
    next();
    stb = 1'b0; we = 1'b0;
    bus_rd(4'd1, v);
    check("t5_set_beats_clear", 32'(v[0]), 32'd1);
    wait_tick();
    stb = 1'b1; we = 1'b1; addr = 4'd4; data_in = 32'd5;
    #1;
    next();
    stb = 1'b0; we = 1'b0;
    bus_rd(4'd4, v);
    check("t5_load_beats_tick", v, 32'd5);

    // 6. asynchronous reset mid-count
    check("t6_irq_before", 32'(irq), 32'd1);
    wait_tick();
    stb = 1'b1; we = 1'b0; addr = 4'd0;
    rst = 1'b0;
    #0.5;
    check("t6_tick_async", 32'(tick), 32'd0);
    check("t6_irq_async", 32'(irq), 32'd0);
    check("t6_ticks_async", data_out, 32'd0);
    addr = 4'd4;
    #0.2;
    check("t6_ch0_async", data_out, 32'd0);
    stb = 1'b0;
    next();
    next();
    rst = 1'b1;
    repeat (12) next();
    bus_rd(4'd0, v);
    check("t6_restart", v, 32'd1);

    // 7. random traffic against the model
    for (int it = 0; it < 2500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 50) begin
        next();
      end else if (r < 70) begin
        bus_rd(4'($urandom_range(0, 15)), v);
      end else if (r < 80) begin
        bus_wr(4'($urandom_range(4, 7)), ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 5)));
      end else if (r < 86) begin
        bus_wr(4'd2, $urandom);
      end else if (r < 90) begin
        bus_wr(4'd1, $urandom);
      end else if (r < 93) begin
        bus_wr(4'd3, $urandom);
      end else if (r < 95) begin
        bus_wr(4'd0, ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom);
      end else if (r < 99) begin
        bus_wr(4'($urandom_range(8, 15)), $urandom);
      end else begin
        rst = 1'b0;
        next();
        rst = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
